mod_n_tick_counter: RTL

Real-time mod-N counter that produces the value written into the design's n-bit storage register. An internal prescaler divides clk into periodic ticks. On each tick the count advances up or down modulo N. A one-cycle write strobe accompanies every count change, and a terminal-count pulse marks each wrap.

---
 rtl/mod_n_tick_counter.sv | 83 ++++++++
 1 files changed

// File: rtl/mod_n_tick_counter.sv
// Mod-N up/down counter advanced by an internal prescaler tick, with a
// one-cycle write strobe on every count change and a terminal-count pulse on wrap.
module mod_n_tick_counter #(
  parameter int WIDTH    = 8,
  parameter int N        = 60,
  parameter int TICK_DIV = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wr_en_o,
  output logic             tc_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(N - 1);
  // One extra bit so N == 2**WIDTH is still representable for the load range check
  localparam logic [WIDTH:0]   MODULUS  = (WIDTH + 1)'(N);

  logic [PW-1:0]    prescaler;
  logic [PW-1:0]    prescaler_next;
  logic [WIDTH-1:0] count_next;
  logic             wr_next;
  logic             tc_next;
  logic             tick;
  logic             load_ok;

  assign tick    = en_i && (prescaler == PS_LAST);
  assign load_ok = ({1'b0, load_val_i} < MODULUS);

  always_comb begin
    count_next     = count_o;
    prescaler_next = prescaler;
    wr_next        = 1'b0;
    tc_next        = 1'b0;
    if (load_i) begin
      // A load discards any coincident tick and restarts the prescale period
      count_next     = load_ok ? load_val_i : '0;
      prescaler_next = '0;
      wr_next        = 1'b1;
    end else if (tick) begin
      prescaler_next = '0;
      wr_next        = 1'b1;
      if (up_i) begin
        if (count_o == CNT_LAST) begin
          count_next = '0;
          tc_next    = 1'b1;
        end else begin
          count_next = count_o + WIDTH'(1);
        end
      end else begin
        if (count_o == '0) begin
          count_next = CNT_LAST;
          tc_next    = 1'b1;
        end else begin
          count_next = count_o - WIDTH'(1);
        end
      end
    end else if (en_i) begin
      prescaler_next = prescaler + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_o   <= '0;
      prescaler <= '0;
      wr_en_o   <= 1'b0;
      tc_o      <= 1'b0;
    end else begin
      count_o   <= count_next;
      prescaler <= prescaler_next;
      wr_en_o   <= wr_next;
      tc_o      <= tc_next;
    end
  end

endmodule
